// File: rtl/rr_mask_arb_if.sv
// rr_mask_arb_if: request/grant/ack bundle between requesters and the round-robin arbiter
interface rr_mask_arb_if #(parameter int N = 8);
  localparam int W_ENC = $clog2(N);
  logic [N-1:0]     req;
  logic             ack;
  logic [N-1:0]     gnt;
  logic [W_ENC-1:0] gnt_enc;
  logic             gnt_vld;
  modport master (input req, ack, output gnt, gnt_enc, gnt_vld);
  modport slave  (output req, ack, input gnt, gnt_enc, gnt_vld);
endinterface

// File: rtl/rr_mask_arb.sv
// rr_mask_arb: masked round-robin arbiter with a registered grant held until ack
module rr_mask_arb #(parameter int N = 8) (
  input logic          clk,
  input logic          rst,
  rr_mask_arb_if.master bus
);
  localparam int W_ENC = $clog2(N);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [W_ENC-1:0] ptr, ptr_nxt, enc_q, p, win;
  logic [N-1:0] hi, cand;
  logic accept;
  // the pointer advances past the accepted grant, so arbitration on an ack cycle already uses the new ptr
  always_comb begin
    accept = state == GRANT && bus.ack;
    ptr_nxt = (enc_q == W_ENC'(N - 1)) ? '0 : enc_q + W_ENC'(1);
    p = accept ? ptr_nxt : ptr;
    hi = bus.req & ~((N'(1) << p) - N'(1));
    cand = |hi ? hi : bus.req;
    win = '0;
    for (int i = N - 1; i >= 0; i--) win = cand[i] ? W_ENC'(i) : win;
  end
  // re-arbitrate when idle or on ack; otherwise the outstanding grant is held
  always_comb state_nxt = (state == IDLE || bus.ack) ? (|bus.req ? GRANT : IDLE) : GRANT;
  // state, pointer and granted index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      enc_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) ptr <= ptr_nxt;
      if (state == IDLE || bus.ack) enc_q <= win;
    end
  end
  // grant outputs decoded from registered state, forced to zero while idle
  always_comb begin
    bus.gnt_vld = state == GRANT;
    bus.gnt_enc = state == GRANT ? enc_q : '0;
    bus.gnt = state == GRANT ? N'(1) << enc_q : '0;
  end
endmodule

// File: tb/tb_rr_mask_arb.sv
// tb_rr_mask_arb: directed tests of the round-robin arbiter at N=8 and N=5
module tb_rr_mask_arb;
  logic clk, rst;
  int errors = 0;
  int checks = 0;
  rr_mask_arb_if #(.N(8)) bus8 ();
  rr_mask_arb_if #(.N(5)) bus5 ();
  rr_mask_arb #(.N(8)) dut (.clk(clk), .rst(rst), .bus(bus8));
  rr_mask_arb #(.N(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (!rst) begin
    checks++;
    if (!($onehot0(bus8.gnt) && bus8.gnt_vld == |bus8.gnt && (!bus8.gnt_vld || bus8.gnt == 8'(1) << bus8.gnt_enc) && bus8.gnt_enc < 8)) begin
      errors++;
      $display("FAIL inv8 gnt=%h enc=%0d vld=%b", bus8.gnt, bus8.gnt_enc, bus8.gnt_vld);
    end
    checks++;
    if (!($onehot0(bus5.gnt) && bus5.gnt_vld == |bus5.gnt && (!bus5.gnt_vld || bus5.gnt == 5'(1) << bus5.gnt_enc) && bus5.gnt_enc < 5)) begin
      errors++;
      $display("FAIL inv5 gnt=%h enc=%0d vld=%b", bus5.gnt, bus5.gnt_enc, bus5.gnt_vld);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    bus8.req = '0;
    bus8.ack = 0;
    bus5.req = '0;
    bus5.ack = 0;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    bus8.req = 8'h05;
    bus8.ack = 0;
    bus5.req = '0;
    bus5.ack = 0;
    #1;
    checks++;
    if (bus8.gnt !== 8'h00 || bus8.gnt_enc !== 3'd0 || bus8.gnt_vld !== 1'b0 || dut.ptr !== 3'd0) begin
      errors++;
      $display("FAIL reset gnt=%h enc=%0d vld=%b ptr=%0d want 00/0/0/0", bus8.gnt, bus8.gnt_enc, bus8.gnt_vld, dut.ptr);
    end
    step();
    rst = 0;
  endtask

  task automatic test_two_req();
    logic [2:0] exp [4] = '{3'd0, 3'd2, 3'd0, 3'd2};
    bus8.req = 8'h05;
    bus8.ack = 0;
    step();
    checks++;
    if (bus8.gnt !== 8'h01) begin
      errors++;
      $display("FAIL two_req_first gnt=%h want 01", bus8.gnt);
    end
    bus8.ack = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus8.gnt_enc !== exp[i] || bus8.gnt_vld !== 1'b1) begin
        errors++;
        $display("FAIL two_req[%0d] enc=%0d vld=%b want %0d/1", i, bus8.gnt_enc, bus8.gnt_vld, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus8.req = 8'hFF;
    bus8.ack = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (bus8.gnt_enc !== 3'(i % 8) || bus8.gnt_vld !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d] enc=%0d vld=%b want %0d/1", i, bus8.gnt_enc, bus8.gnt_vld, i % 8);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    bus8.req = 8'h08;
    step();
    for (int i = 0; i < 5; i++) begin
      bus8.req = i[0] ? 8'h00 : 8'h81;
      step();
      checks++;
      if (bus8.gnt !== 8'h08 || bus8.gnt_enc !== 3'd3) begin
        errors++;
        $display("FAIL hold[%0d] gnt=%h enc=%0d want 08/3", i, bus8.gnt, bus8.gnt_enc);
      end
    end
    bus8.req = 8'h81;
    bus8.ack = 1;
    step();
    checks++;
    if (bus8.gnt_enc !== 3'd7) begin
      errors++;
      $display("FAIL hold_next enc=%0d want 7", bus8.gnt_enc);
    end
  endtask

  task automatic test_idle_wrap();
    do_reset();
    bus8.req = 8'h10;
    step();
    bus8.req = 8'h00;
    bus8.ack = 1;
    step();
    checks++;
    if (bus8.gnt_vld !== 1'b0 || bus8.gnt !== 8'h00 || dut.ptr !== 3'd5) begin
      errors++;
      $display("FAIL to_idle vld=%b gnt=%h ptr=%0d want 0/00/5", bus8.gnt_vld, bus8.gnt, dut.ptr);
    end
    bus8.ack = 0;
    bus8.req = 8'h02;
    step();
    checks++;
    if (bus8.gnt_enc !== 3'd1 || bus8.gnt !== 8'h02) begin
      errors++;
      $display("FAIL wrap enc=%0d gnt=%h want 1/02", bus8.gnt_enc, bus8.gnt);
    end
    bus8.req = 8'h22;
    bus8.ack = 1;
    step();
    checks++;
    if (bus8.gnt_enc !== 3'd5) begin
      errors++;
      $display("FAIL after_wrap enc=%0d want 5", bus8.gnt_enc);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus8.req = 8'h40;
    step();
    checks++;
    if (bus8.gnt_enc !== 3'd6) begin
      errors++;
      $display("FAIL pre_rst enc=%0d want 6", bus8.gnt_enc);
    end
    rst = 1;
    #1;
    checks++;
    if (bus8.gnt !== 8'h00 || bus8.gnt_vld !== 1'b0) begin
      errors++;
      $display("FAIL async_rst gnt=%h vld=%b want 00/0", bus8.gnt, bus8.gnt_vld);
    end
    rst = 0;
    bus8.req = 8'h80;
    step();
    checks++;
    if (bus8.gnt_enc !== 3'd7 || bus8.gnt !== 8'h80) begin
      errors++;
      $display("FAIL post_rst enc=%0d gnt=%h want 7/80", bus8.gnt_enc, bus8.gnt);
    end
  endtask

  task automatic test_n5();
    do_reset();
    bus5.req = 5'h1F;
    bus5.ack = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (bus5.gnt_enc !== 3'(i % 5) || bus5.gnt_vld !== 1'b1) begin
        errors++;
        $display("FAIL n5[%0d] enc=%0d vld=%b want %0d/1", i, bus5.gnt_enc, bus5.gnt_vld, i % 5);
      end
    end
    bus5.req = 5'h00;
    step();
    step();
    checks++;
    if (bus5.gnt_vld !== 1'b0 || dut5.ptr !== 3'd1) begin
      errors++;
      $display("FAIL n5_idle_ack vld=%b ptr=%0d want 0/1", bus5.gnt_vld, dut5.ptr);
    end
    bus5.ack = 0;
    bus5.req = 5'h1F;
    step();
    checks++;
    if (bus5.gnt_enc !== 3'd1) begin
      errors++;
      $display("FAIL n5_resume enc=%0d want 1", bus5.gnt_enc);
    end
  endtask

  initial begin
    test_reset();
    test_two_req();
    test_back_to_back();
    test_hold();
    test_idle_wrap();
    test_async_reset();
    test_n5();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rr_mask_arb.md
Name: rr_mask_arb

Overview:
- Round-robin arbiter that shares one downstream resource among N requesters.
- Priority is built from a thermometer mask of the form (1 << ptr) - 1, inverted. It selects requests at index >= ptr first, then falls back to the unmasked request vector.
- The grant is registered and held until the resource acknowledges it. The block sits in front of any shared datapath port (memory port, bus master, pipeline slot).

Parameters:
- N, 8, number of requesters; N >= 2, power of two not required.
- W_ENC, $clog2(N), width of the encoded grant (derived; do not override).

Ports:
- clk      input   1      clock; all state updates on the rising edge
- rst      input   1      asynchronous, active-high reset
- req      input   N      per-requester request; bit i = requester i
- ack      input   1      resource accepted the current grant this cycle
- gnt      output  N      one-hot grant, registered; all zero when idle
- gnt_enc  output  W_ENC  binary index of the granted requester; 0 when idle
- gnt_vld  output  1      a grant is outstanding (equals |gnt)

Behaviour:
- Reset (asynchronous, on rst high):
  - gnt=0, gnt_enc=0, gnt_vld=0, ptr=0, state=IDLE.
  - Applies immediately, including mid-grant; the outstanding grant is dropped without ack.
- State machine, two states:
  - IDLE: gnt_vld=0. If |req at the edge, load the arbitration winner into gnt/gnt_enc, set gnt_vld=1 and go to GRANT. Otherwise stay in IDLE.
  - GRANT: gnt, gnt_enc and gnt_vld are held stable while ack=0. This holds regardless of req changes, including the granted requester dropping req.
  - GRANT with ack=1: ptr <= (gnt_enc == N-1) ? 0 : gnt_enc+1. In the same edge, re-arbitrate against the current req using the updated ptr.
    - If a winner exists: load it and stay in GRANT. This gives back-to-back grants with no bubble.
    - If no winner: clear the grant and go to IDLE.
- Arbitration, combinational from req and the effective pointer p:
  - p = ptr in IDLE; p = next ptr on an ack cycle.
  - hi = req & ~((1 << p) - 1), computed at N bits.
  - If hi != 0, winner = lowest set bit of hi. Else winner = lowest set bit of req.
  - No winner when req = 0.
- Latency:
  - req asserted in IDLE at cycle t -> gnt visible at t+1.
  - ack at cycle t with other requests pending -> next grant visible at t+1.
- Fairness: a continuously requesting requester is granted within N grants.
- ptr changes only on an accepted grant (ack while GRANT). It is retained through IDLE periods.
- ack while IDLE is ignored: no state change, ptr unchanged.
- Granting the same requester twice in a row is legal only when it is the sole requester.
- Invariants (checked by bench assertions):
  - gnt is one-hot or zero.
  - gnt_vld == |gnt.
  - gnt == (1 << gnt_enc) whenever gnt_vld.
  - gnt_enc < N.

Test Plan:
1. Reset, req=8'b0000_0101 held, ack every cycle from the first grant -> gnt_enc sequence 0,2,0,2. gnt=8'h01 on the cycle after req.
2. req=8'hFF held, ack=1 every cycle -> gnt_enc 0,1,2,...,7,0 with gnt_vld continuously 1 (no bubble).
3. Grant on requester 3, ack=0 for 5 cycles while req toggles to 8'h81 -> gnt stays 8'h08, gnt_enc=3. Ack -> next gnt_enc=7.
4. Grant requester 4, ack with req=0 -> gnt_vld=0 next cycle, ptr=5. Later req=8'b0000_0010 -> gnt_enc=1 (wrap fallback). Then req=8'h22 after ack -> gnt_enc=5.
5. rst pulsed mid-grant (gnt_enc=6) -> gnt=0, gnt_vld=0 immediately without a clock. After release, req=8'h80 -> gnt_enc=7 one cycle later.
6. N=5 build: req=5'h1F, ack each cycle -> gnt_enc 0,1,2,3,4,0. ack while idle with req=0 -> no grant, ptr unchanged.
